crc_stream_hash: RTL and testbench

- Streaming, multi-channel successor to the single-shot combinational string CRC.
- Accepts a variable-length byte string over several clock cycles, BYTES_PER_CLK bytes per beat, using valid/ready with sop/eop framing.
- Computes HASH_CNT independent CRCs in parallel, one per Bloom-filter hash function, each with its own init value.
- Presents them, plus the string length, in a registered result slot. It sits between the string parser and the Bloom filter bit-array update/lookup logic.

---
 rtl/crc_pkg.sv | 44 ++++
 rtl/crc_lanes.sv | 31 +++
 rtl/crc_stream_hash.sv | 122 ++++++++++++
 tb/tb_crc_stream_hash.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared CRC arithmetic and types for the streaming Bloom-filter hash front end.
// crc_step is width-generic up to CrcMaxW bits; callers truncate the result to their width.
package crc_pkg;

  localparam int unsigned CrcMaxW  = 32;
  localparam int unsigned ByteMaxW = 16;
  localparam int unsigned CrcIdxW  = $clog2(CrcMaxW);
  localparam int unsigned ByteIdxW = $clog2(ByteMaxW);

  typedef enum logic {StIdle, StAccum} state_e;

  function automatic int unsigned calc_empty_w(input int unsigned bytes_per_clk);
    return (bytes_per_clk > 1) ? $clog2(bytes_per_clk) : 1;
  endfunction

  localparam int unsigned DefaultBytesPerClk = 4;
  localparam int unsigned DefaultEmptyW      = calc_empty_w(DefaultBytesPerClk);

  // MSB-first, non-reflected shift of one byte into a width-bit CRC register.
  function automatic logic [CrcMaxW-1:0] crc_step(input logic [ByteMaxW-1:0] data,
                                                  input logic [CrcMaxW-1:0]  crc,
                                                  input logic [CrcMaxW-1:0]  poly,
                                                  input int unsigned         width,
                                                  input int unsigned         byte_w);
    logic [CrcMaxW-1:0] c;
    logic [CrcMaxW-1:0] mask;
    logic               fb;
    mask = (width >= CrcMaxW) ? '1 : ((CrcMaxW'(1) << width) - CrcMaxW'(1));
    c    = crc & mask;
    for (int i = ByteMaxW - 1; i >= 0; i--) begin
      if (i < int'(byte_w)) begin
        fb = c[CrcIdxW'(width - 1)] ^ data[ByteIdxW'(i)];
        c  = (c << 1) & mask;
        if (fb) c = c ^ (poly & mask);
      end
    end
    return c;
  endfunction

  function automatic logic [11:0] crc_8d95(input logic [7:0] data, input logic [11:0] crc);
    return 12'(crc_step(ByteMaxW'(data), CrcMaxW'(crc), CrcMaxW'(12'h8D5), 12, 8));
  endfunction

endpackage

// File: rtl/crc_lanes.sv
// Combinational chain of per-lane CRC byte steps; only the first lane_cnt_i lanes are applied,
// lane 0 first.
module crc_lanes
  import crc_pkg::*;
#(
  parameter int unsigned       BYTE_W        = 8,
  parameter int unsigned       WIDTH         = 12,
  parameter logic [WIDTH-1:0]  POLY          = 12'h8D5,
  parameter int unsigned       BYTES_PER_CLK = 4,
  parameter int unsigned       CNT_W         = $clog2(BYTES_PER_CLK + 1)
) (
  input  logic [WIDTH-1:0]                      crc_i,
  input  logic [BYTES_PER_CLK-1:0][BYTE_W-1:0]  data_i,
  input  logic [CNT_W-1:0]                      lane_cnt_i,
  output logic [WIDTH-1:0]                      crc_o
);

  logic [BYTES_PER_CLK:0][WIDTH-1:0] stage;

  assign stage[0] = crc_i;

  for (genvar g = 0; g < BYTES_PER_CLK; g++) begin : gen_lane
    logic [WIDTH-1:0] stepped;
    assign stepped = WIDTH'(crc_step(ByteMaxW'(data_i[g]), CrcMaxW'(stage[g]),
                                     CrcMaxW'(POLY), WIDTH, BYTE_W));
    assign stage[g+1] = (lane_cnt_i > CNT_W'(g)) ? stepped : stage[g];
  end

  assign crc_o = stage[BYTES_PER_CLK];

endmodule

// File: rtl/crc_stream_hash.sv
// Streaming multi-channel CRC hash: accumulates sop/eop-framed byte strings and delivers
// HASH_CNT CRCs plus the byte length through a one-entry registered result slot.
module crc_stream_hash
  import crc_pkg::*;
#(
  parameter int unsigned                        BYTE_W        = 8,
  parameter int unsigned                        WIDTH         = 12,
  parameter logic [WIDTH-1:0]                   POLY          = 12'h8D5,
  parameter int unsigned                        BYTES_PER_CLK = 4,
  parameter int unsigned                        HASH_CNT      = 4,
  parameter logic [HASH_CNT-1:0][WIDTH-1:0]     INITS         = {12'h001, 12'h0A5, 12'h35C,
                                                                 12'hFFF},
  parameter int unsigned                        LEN_W         = 16,
  localparam int unsigned                       EMPTY_W       = calc_empty_w(BYTES_PER_CLK)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic [BYTES_PER_CLK-1:0][BYTE_W-1:0]  data_i,
  input  logic                                  valid_i,
  input  logic                                  sop_i,
  input  logic                                  eop_i,
  input  logic [EMPTY_W-1:0]                    empty_i,
  output logic                                  ready_o,
  output logic [HASH_CNT-1:0][WIDTH-1:0]        hash_o,
  output logic [LEN_W-1:0]                      len_o,
  output logic                                  hash_valid_o,
  input  logic                                  hash_ready_i,
  output logic                                  err_o
);

  localparam int unsigned CntW = $clog2(BYTES_PER_CLK + 1);

  state_e                         state_q, state_d;
  logic [HASH_CNT-1:0][WIDTH-1:0] acc_q, acc_d;
  logic [HASH_CNT-1:0][WIDTH-1:0] hash_q, hash_d;
  logic [HASH_CNT-1:0][WIDTH-1:0] seed, lanes_out;
  logic [LEN_W-1:0]               len_q, len_d, len_out_q, len_out_d;
  logic [LEN_W-1:0]               len_base, len_new;
  logic [LEN_W:0]                 len_sum;
  logic                           hash_valid_q, hash_valid_d;
  logic                           err_q, err_d;
  logic                           accept, take;
  logic [CntW-1:0]                lane_cnt;

  assign ready_o = !hash_valid_q || hash_ready_i;
  assign accept  = valid_i && ready_o;
  // A beat only contributes if it opens a string or continues one; stray beats in idle are dropped.
  assign take    = accept && (sop_i || (state_q == StAccum));

  always_comb begin
    lane_cnt = CntW'(BYTES_PER_CLK);
    if (eop_i) lane_cnt = CntW'(BYTES_PER_CLK) - CntW'(empty_i);
  end

  assign seed     = sop_i ? INITS : acc_q;
  assign len_base = sop_i ? '0 : len_q;
  assign len_sum  = {1'b0, len_base} + (LEN_W + 1)'(lane_cnt);
  assign len_new  = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];

  for (genvar h = 0; h < HASH_CNT; h++) begin : gen_chan
    crc_lanes #(
      .BYTE_W       (BYTE_W),
      .WIDTH        (WIDTH),
      .POLY         (POLY),
      .BYTES_PER_CLK(BYTES_PER_CLK),
      .CNT_W        (CntW)
    ) u_lanes (
      .crc_i     (seed[h]),
      .data_i    (data_i),
      .lane_cnt_i(lane_cnt),
      .crc_o     (lanes_out[h])
    );
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    len_d        = len_q;
    hash_d       = hash_q;
    len_out_d    = len_out_q;
    hash_valid_d = hash_valid_q;
    err_d        = accept && (((state_q == StIdle) && !sop_i) || ((state_q == StAccum) && sop_i));
    if (hash_ready_i) hash_valid_d = 1'b0;
    if (take) begin
      acc_d   = lanes_out;
      len_d   = len_new;
      state_d = StAccum;
      if (eop_i) begin
        hash_d       = lanes_out;
        len_out_d    = len_new;
        hash_valid_d = 1'b1;
        state_d      = StIdle;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= StIdle;
      acc_q        <= INITS;
      len_q        <= '0;
      hash_q       <= '0;
      len_out_q    <= '0;
      hash_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      len_q        <= len_d;
      hash_q       <= hash_d;
      len_out_q    <= len_out_d;
      hash_valid_q <= hash_valid_d;
      err_q        <= err_d;
    end
  end

  assign hash_o       = hash_q;
  assign len_o        = len_out_q;
  assign hash_valid_o = hash_valid_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_crc_stream_hash.sv
// Directed + randomized bench for crc_stream_hash; expected CRCs come from polynomial long
// division of the init-augmented message.
module tb_crc_stream_hash;

  localparam int unsigned BPC = 4;
  localparam int unsigned W   = 12;
  localparam int unsigned HC  = 4;
  localparam logic [HC-1:0][W-1:0] INITS = {12'h001, 12'h0A5, 12'h35C, 12'hFFF};
  localparam logic [HC-1:0][W-1:0] ZINITS = '0;
  localparam logic [W-1:0] POLY = 12'h8D5;

  typedef byte unsigned bq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [BPC-1:0][7:0] data = '0;
  logic valid = 1'b0, sop = 1'b0, eop = 1'b0, hash_ready = 1'b1;
  logic [1:0] empty = '0;
  logic ready, hv, err, ready_z, hv_z, err_z;
  logic [HC-1:0][W-1:0] hash, hash_z;
  logic [15:0] len, len_z;

  logic [0:0][7:0] data1 = '0;
  logic valid1 = 1'b0, sop1 = 1'b0, eop1 = 1'b0, hash_ready1 = 1'b1;
  logic [0:0] empty1 = '0;
  logic ready1, hv1, err1;
  logic [HC-1:0][W-1:0] hash1;
  logic [15:0] len1;

  crc_stream_hash u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .valid_i(valid), .sop_i(sop), .eop_i(eop),
    .empty_i(empty), .ready_o(ready), .hash_o(hash), .len_o(len), .hash_valid_o(hv),
    .hash_ready_i(hash_ready), .err_o(err)
  );

  crc_stream_hash #(.INITS(ZINITS)) u_dut_z (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .valid_i(valid), .sop_i(sop), .eop_i(eop),
    .empty_i(empty), .ready_o(ready_z), .hash_o(hash_z), .len_o(len_z), .hash_valid_o(hv_z),
    .hash_ready_i(hash_ready), .err_o(err_z)
  );

  crc_stream_hash #(.BYTES_PER_CLK(1)) u_dut_b1 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data1), .valid_i(valid1), .sop_i(sop1),
    .eop_i(eop1), .empty_i(empty1), .ready_o(ready1), .hash_o(hash1), .len_o(len1),
    .hash_valid_o(hv1), .hash_ready_i(hash_ready1), .err_o(err1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC = remainder of (msg * x^W + init * x^(8n)) divided by the generator.
  function automatic logic [W-1:0] ref_crc(input bq_t msg, input logic [W-1:0] init);
    int          l = msg.size() * 8;
    bit          arr[];
    logic [W:0]  g = {1'b1, POLY};
    logic [W-1:0] r = '0;
    arr = new[l + W];
    for (int i = 0; i < msg.size(); i++)
      for (int b = 0; b < 8; b++) arr[i*8+b] = ((msg[i] >> (7 - b)) & 8'd1) != 0;
    for (int j = 0; j < W; j++) arr[j] ^= ((init >> (W - 1 - j)) & W'(1)) != 0;
    for (int i = 0; i < l; i++)
      if (arr[i]) for (int k = 0; k <= W; k++) arr[i+k] ^= ((g >> (W - k)) & (W+1)'(1)) != 0;
    for (int k = 0; k < W; k++) r = {r[W-2:0], arr[l+k]};
    return r;
  endfunction

  function automatic logic [HC-1:0][W-1:0] ref_all(input bq_t msg,
                                                   input logic [HC-1:0][W-1:0] iv);
    return {ref_crc(msg, iv[3]), ref_crc(msg, iv[2]), ref_crc(msg, iv[1]), ref_crc(msg, iv[0])};
  endfunction

  function automatic logic [BPC-1:0][7:0] pack4(input bq_t msg, input int start);
    byte unsigned ln[4];
    for (int l = 0; l < 4; l++) ln[l] = (start + l < msg.size()) ? msg[start+l] : 8'($urandom);
    return {ln[3], ln[2], ln[1], ln[0]};
  endfunction

  function automatic bq_t rand_msg(input int n);
    bq_t m;
    for (int i = 0; i < n; i++) m.push_back(8'($urandom));
    return m;
  endfunction

  // Present one beat and hold it until accepted; returns #1 after the accepting edge.
  task automatic send_beat(input logic [BPC-1:0][7:0] d, input logic s, input logic e,
                           input logic [1:0] em);
    data = d; sop = s; eop = e; empty = em; valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready) begin
        @(posedge clk); #1;
        valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    valid = 1'b0;
    check("accept_timeout", 64'(ready), 64'(1));
  endtask

  task automatic send_string(input bq_t msg);
    int nb = (msg.size() + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      send_beat(pack4(msg, b * 4), b == 0, b == nb - 1,
                (b == nb - 1) ? 2'(nb * 4 - msg.size()) : 2'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t m, m2, y;
    logic [HC-1:0][W-1:0] exp_h, exp_b, abc_h;

    repeat (3) @(posedge clk);
    #1;
    check("rst_hv", 64'(hv), 64'(0));
    check("rst_hash", 64'(hash), 64'(0));
    check("rst_len", 64'(len), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 64'(ready), 64'(1));
    check("post_rst_ready_z", 64'(ready_z), 64'(1));

    // Zero-init channel set over an all-zero single beat.
    m = {8'h00, 8'h00, 8'h00, 8'h00};
    send_string(m);
    check("zero_hv", 64'(hv_z), 64'(1));
    check("zero_hash", 64'(hash_z), 64'(0));
    check("zero_len", 64'(len_z), 64'(4));
    check("zero_err", 64'(err_z), 64'(0));
    check("zero_main_hash", 64'(hash), 64'(ref_all(m, INITS)));
    @(posedge clk); #1;
    check("popped_hv", 64'(hv), 64'(0));

    // "abc" in one 4-lane beat vs three 1-lane beats.
    m = {8'h61, 8'h62, 8'h63};
    send_string(m);
    abc_h = hash;
    check("abc_hash", 64'(hash), 64'(ref_all(m, INITS)));
    check("abc_len", 64'(len), 64'(3));
    for (int i = 0; i < 3; i++) begin
      data1 = {m[i]}; sop1 = (i == 0); eop1 = (i == 2); valid1 = 1'b1;
      @(posedge clk); #1;
    end
    valid1 = 1'b0;
    check("abc_b1_hv", 64'(hv1), 64'(1));
    check("abc_b1_vs_b4", 64'(hash1), 64'(abc_h));
    check("abc_b1_ref", 64'(hash1), 64'(ref_all(m, INITS)));
    check("abc_b1_len", 64'(len1), 64'(3));
    check("abc_b1_err", 64'(err1 | !ready1), 64'(0));

    // Random strings of assorted lengths and empty counts.
    repeat (12) begin
      m = rand_msg(int'($urandom_range(1, 13)));
      send_string(m);
      check("rand_hv", 64'(hv), 64'(1));
      check("rand_hash", 64'(hash), 64'(ref_all(m, INITS)));
      check("rand_len", 64'(len), 64'(m.size()));
    end

    // Ten bytes in three beats, then hold the result for five cycles.
    @(posedge clk); #1;
    hash_ready = 1'b0;
    m = rand_msg(10);
    exp_h = ref_all(m, INITS);
    send_string(m);
    check("stall_hv", 64'(hv), 64'(1));
    check("stall_hash", 64'(hash), 64'(exp_h));
    check("stall_len", 64'(len), 64'(10));
    m2 = rand_msg(4);
    data = pack4(m2, 0); sop = 1'b1; eop = 1'b1; empty = 2'd0; valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_ready", 64'(ready), 64'(0));
      check("stall_held", 64'(hash), 64'(exp_h));
      check("stall_hv_held", 64'(hv), 64'(1));
      @(posedge clk); #1;
    end
    hash_ready = 1'b1;
    @(negedge clk);
    check("unstall_ready", 64'(ready), 64'(1));
    @(posedge clk); #1;
    valid = 1'b0;
    check("next_hv", 64'(hv), 64'(1));
    check("next_hash", 64'(hash), 64'(ref_all(m2, INITS)));
    check("next_len", 64'(len), 64'(4));

    // Back-to-back single-beat strings with the consumer always ready.
    m = rand_msg(4);
    m2 = rand_msg(4);
    exp_h = ref_all(m, INITS);
    exp_b = ref_all(m2, INITS);
    data = pack4(m, 0); sop = 1'b1; eop = 1'b1; empty = 2'd0; valid = 1'b1;
    @(posedge clk); #1;
    check("b2b_a_hv", 64'(hv), 64'(1));
    check("b2b_a_hash", 64'(hash), 64'(exp_h));
    data = pack4(m2, 0);
    @(posedge clk); #1;
    valid = 1'b0;
    check("b2b_b_hv", 64'(hv), 64'(1));
    check("b2b_b_hash", 64'(hash), 64'(exp_b));
    @(posedge clk); #1;
    check("b2b_drain_hv", 64'(hv), 64'(0));

    // Beat without sop while idle.
    data = pack4(rand_msg(4), 0); sop = 1'b0; eop = 1'b1; empty = 2'd0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    check("nosop_err", 64'(err), 64'(1));
    check("nosop_hv", 64'(hv), 64'(0));
    @(posedge clk); #1;
    check("nosop_err_clr", 64'(err), 64'(0));
    check("nosop_hv_after", 64'(hv), 64'(0));

    // sop in mid-string abandons the first string.
    send_beat(pack4(rand_msg(4), 0), 1'b1, 1'b0, 2'd0);
    y = rand_msg(8);
    send_beat(pack4(y, 0), 1'b1, 1'b0, 2'd0);
    check("midsop_err", 64'(err), 64'(1));
    send_beat(pack4(y, 4), 1'b0, 1'b1, 2'd0);
    check("midsop_hv", 64'(hv), 64'(1));
    check("midsop_hash", 64'(hash), 64'(ref_all(y, INITS)));
    check("midsop_len", 64'(len), 64'(8));
    check("midsop_err_clr", 64'(err), 64'(0));

    // Reset with a full slot drops the result without a clock edge.
    @(posedge clk); #1;
    hash_ready = 1'b0;
    m = rand_msg(3);
    send_string(m);
    check("prerst_hv", 64'(hv), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_hv", 64'(hv), 64'(0));
    check("async_rst_hash", 64'(hash), 64'(0));
    check("async_rst_len", 64'(len), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    hash_ready = 1'b1;
    @(posedge clk); #1;

    // Reset mid-string: a following non-sop beat must be treated as idle.
    send_beat(pack4(rand_msg(4), 0), 1'b1, 1'b0, 2'd0);
    #2 rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(pack4(rand_msg(4), 0), 1'b0, 1'b1, 2'd1);
    check("rst_accum_err", 64'(err), 64'(1));
    check("rst_accum_hv", 64'(hv), 64'(0));
    m = rand_msg(6);
    send_string(m);
    check("post_rst_hv", 64'(hv), 64'(1));
    check("post_rst_hash", 64'(hash), 64'(ref_all(m, INITS)));
    check("post_rst_len", 64'(len), 64'(6));

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
